// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one physical-memory port
// between the I-cache and D-cache line controllers.
module pmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic              i_pmem_resp,
  output logic [LINE_W-1:0] i_pmem_rdata,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic              d_pmem_resp,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata,
  output logic              busy,
  output logic              grant_d
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              state;
  logic                owner;
  logic                op_write;
  logic                rr_next;
  logic [ADDR_W-1:0]   addr_q;
  logic [LINE_W-1:0]   wdata_q;

  logic req_i;
  logic req_d;
  logic win_d;

  assign req_i = i_pmem_read;
  assign req_d = d_pmem_read | d_pmem_write;
  // D wins when alone, or on a tie when it holds the turn
  assign win_d = req_d & (~req_i | rr_next);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= 1'b0;
      op_write <= 1'b0;
      rr_next  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_i | req_d) begin
            state    <= BUSY;
            owner    <= win_d;
            op_write <= win_d & d_pmem_write;
            addr_q   <= win_d ? d_pmem_address
                              : i_pmem_address;
            wdata_q  <= d_pmem_wdata;
          end
        end
        BUSY: begin
          if (pmem_resp) begin
            state   <= IDLE;
            rr_next <= ~owner;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy         = (state == BUSY);
  assign grant_d      = owner;
  assign pmem_read    = busy & ~op_write;
  assign pmem_write   = busy & op_write;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  // only the owner sees the completion strobe
  assign i_pmem_resp  = busy & pmem_resp & ~owner;
  assign d_pmem_resp  = busy & pmem_resp & owner;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Shares the single physical-memory port between the instruction-cache and data-cache controllers in the split-L1 memory system.
- Each cache controller sees a private pmem-style port: read/write held until resp.
- The arbiter grants one requester per line transaction using round-robin and latches that request's op, address and data.
- It drives the shared port from those latched values and routes pmem_resp back to the owner only.

Parameters:
- ADDR_W, 32, physical address width
- LINE_W, 256, cache line width in bits

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_pmem_read  in  1  I-cache line read request, held until i_pmem_resp
- i_pmem_address  in  ADDR_W  I-cache line address
- i_pmem_resp  out  1  I-cache transaction complete, one cycle
- i_pmem_rdata  out  LINE_W  read line to I-cache
- d_pmem_read  in  1  D-cache line read request, held until d_pmem_resp
- d_pmem_write  in  1  D-cache write-back request, held until d_pmem_resp
- d_pmem_address  in  ADDR_W  D-cache line address
- d_pmem_wdata  in  LINE_W  D-cache write-back line
- d_pmem_resp  out  1  D-cache transaction complete, one cycle
- d_pmem_rdata  out  LINE_W  read line to D-cache
- pmem_read  out  1  shared-port read
- pmem_write  out  1  shared-port write
- pmem_address  out  ADDR_W  shared-port address
- pmem_wdata  out  LINE_W  shared-port write data
- pmem_resp  in  1  shared-port completion, one cycle
- pmem_rdata  in  LINE_W  shared-port read data, valid with pmem_resp
- busy  out  1  a transaction is granted and outstanding
- grant_d  out  1  current or most recent grant owner (1 = D-cache, 0 = I-cache)

Behaviour:

States:
- IDLE: no transaction outstanding.
- BUSY: one transaction granted and outstanding.

Registers:
- state, owner, op_write, addr_q, wdata_q, rr_next (1 = D-cache has priority on tie).

Reset:
- Asserted asynchronously when rst_n=0.
- Values: state=IDLE, owner=0, op_write=0, addr_q=0, wdata_q=0, rr_next=0 (I-cache favoured first).
- All outputs 0: pmem_read, pmem_write, pmem_address, pmem_wdata, i/d_pmem_resp, busy, grant_d.
- Reset mid-transaction drops the shared request immediately; any later pmem_resp is ignored in IDLE.

Request definitions:
- reqI = i_pmem_read.
- reqD = d_pmem_read | d_pmem_write.

IDLE:
- No request: stay in IDLE.
- Only one of reqI/reqD asserted: grant that requester.
- Both asserted: grant D-cache if rr_next=1, else I-cache.
- On grant, at the clock edge:
  - state→BUSY, owner←winner.
  - addr_q←winner address.
  - op_write←d_pmem_write if D-cache won, else 0.
  - wdata_q←d_pmem_wdata.
- Arbitration latency is one cycle: the shared port asserts the cycle after the request is first seen in IDLE.

BUSY:
- pmem_read = !op_write; pmem_write = op_write.
- pmem_address = addr_q; pmem_wdata = wdata_q.
- Requester inputs are ignored in BUSY; a requester that drops its request early does not abort the transaction.
- On pmem_resp=1:
  - Assert owner's resp combinationally in that same cycle.
  - state→IDLE; rr_next←!owner.
- pmem_resp never reaches the non-owner.

Outputs and gating:
- i_pmem_rdata and d_pmem_rdata are driven from pmem_rdata as a broadcast; only the resp strobes are gated.
- pmem_read and pmem_write are 0 in IDLE.
- busy = (state==BUSY); grant_d = owner.
- pmem_resp in IDLE is ignored.

Sequencing guarantee:
- At least one IDLE cycle separates consecutive transactions; no grant is made in the same cycle as pmem_resp.
- A D-cache write-back immediately followed by a refill read loses to a waiting I-cache read, because rr_next points to I after the D-cache completes. This is required to prevent starvation.

Illegal input:
- d_pmem_read and d_pmem_write asserted together: treated as write.
- Worst-case wait for either requester is one foreign transaction.

Test Plan:
- Reset with rst_n=0 while pmem_read=1 in BUSY → all outputs 0 the same cycle. After release with reqI=1 and address 0x0000_1000: pmem_read=1 and pmem_address=0x0000_1000 one cycle later.
- I-cache only reads 0x40; pmem_resp after 3 BUSY cycles with rdata=0xA5 pattern → i_pmem_resp=1 in the resp cycle, d_pmem_resp stays 0, busy falls the next cycle.
- reqI and reqD (read 0x80) asserted in the same cycle from reset → I-cache is served first. Then D-cache is granted in the IDLE cycle after I's resp. pmem_address sequence is 0x40 then 0x80.
- D-cache write-back to 0x200 with wdata=all-ones, I-cache waiting → pmem_write=1 and pmem_wdata=all-ones. After resp, the I-cache read is granted before the D-cache refill of 0x300.
- Continuous reqI and reqD over 6 transactions → grants alternate I,D,I,D,I,D. Each resp goes only to its owner; no back-to-back grant without an IDLE cycle.
- Requester drops d_pmem_write mid-BUSY, or pmem_resp pulses while IDLE → shared write completes with latched addr/wdata. A stray pmem_resp in IDLE produces no requester resp.
